// File: rtl/warp_issue_scheduler_pkg.sv
// Shared GPU scheduler definitions: default sizing, issue-slot payload and
// one-hot index helper.
package warp_issue_scheduler_pkg;

    localparam int DEF_NUM_WARPS = 8;
    localparam int DEF_INSTR_W   = 32;
    localparam int DEF_WID_W     = $clog2(DEF_NUM_WARPS);
    localparam int MAX_WARPS     = 64;

    typedef struct packed {
        logic [DEF_WID_W-1:0]   wid;
        logic [DEF_INSTR_W-1:0] instr;
    } issue_slot_t;

    // Callers zero-extend to MAX_WARPS and size-cast the result back down.
    function automatic int unsigned onehot_to_idx(input logic [MAX_WARPS-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_WARPS; i++) begin
            if (oh[i]) idx = idx | unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/warp_issue_scheduler_if.sv
// Bundle between the warp scheduler, the IBuffers, the branch unit and the
// downstream issue pipe. master = scheduler side.
interface warp_issue_scheduler_if
    import warp_issue_scheduler_pkg::*;
#(
    parameter int NUM_WARPS = DEF_NUM_WARPS,
    parameter int INSTR_W   = DEF_INSTR_W
);
    localparam int WID_W = $clog2(NUM_WARPS);

    logic [NUM_WARPS-1:0]         warp_active;
    logic [NUM_WARPS-1:0]         ibuf_valid;
    logic [NUM_WARPS*INSTR_W-1:0] ibuf_instr;
    logic [NUM_WARPS-1:0]         ibuf_is_branch;
    logic [NUM_WARPS-1:0]         ibuf_is_barrier;
    logic [NUM_WARPS-1:0]         sb_clear;
    logic [NUM_WARPS-1:0]         ibuf_pop;
    logic                         br_resolve_valid;
    logic [WID_W-1:0]             br_resolve_wid;
    logic                         issue_valid;
    logic                         issue_ready;
    logic [WID_W-1:0]             issue_wid;
    logic [INSTR_W-1:0]           issue_instr;
    logic [NUM_WARPS-1:0]         br_pending;
    logic [NUM_WARPS-1:0]         bar_wait;

    modport master (
        input  warp_active, ibuf_valid, ibuf_instr, ibuf_is_branch, ibuf_is_barrier,
               sb_clear, br_resolve_valid, br_resolve_wid, issue_ready,
        output ibuf_pop, issue_valid, issue_wid, issue_instr, br_pending, bar_wait
    );

    modport slave (
        output warp_active, ibuf_valid, ibuf_instr, ibuf_is_branch, ibuf_is_barrier,
               sb_clear, br_resolve_valid, br_resolve_wid, issue_ready,
        input  ibuf_pop, issue_valid, issue_wid, issue_instr, br_pending, bar_wait
    );

endinterface

// File: rtl/warp_issue_scheduler_rr_prioritizer.sv
// Round-robin prioritizer: the last grantee becomes lowest priority; after
// reset bit 0 is highest. Pointer moves only when some request is present.
module rr_prioritizer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_req,
    output logic [WIDTH-1:0] o_grant
);

    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] w_masked;
    logic [WIDTH-1:0] w_pick;

    // r_mask marks the bits strictly above the last grantee.
    assign w_masked = i_req & r_mask;
    assign w_pick   = (|w_masked) ? w_masked : i_req;
    assign o_grant  = w_pick & (~w_pick + WIDTH'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask <= '0;
        end else if (|i_req) begin
            r_mask <= ~(o_grant | (o_grant - WIDTH'(1)));
        end
    end

endmodule

// File: rtl/warp_issue_scheduler.sv
// Per-cycle warp selection into a registered issue slot, with branch-pending
// and barrier-wait blocking held by the scheduler.
module warp_issue_scheduler
    import warp_issue_scheduler_pkg::*;
#(
    parameter int NUM_WARPS = DEF_NUM_WARPS,
    parameter int INSTR_W   = DEF_INSTR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    warp_issue_scheduler_if.master bus
);

    localparam int WID_W = $clog2(NUM_WARPS);

    logic                 w_advance;
    logic [NUM_WARPS-1:0] w_eligible;
    logic [NUM_WARPS-1:0] w_grant;
    logic [WID_W-1:0]     w_grant_idx;
    logic [INSTR_W-1:0]   w_grant_instr;
    logic [NUM_WARPS-1:0] w_res_clr;
    logic [NUM_WARPS-1:0] w_br_next;
    logic [NUM_WARPS-1:0] w_bar_next;
    logic                 w_release;

    logic                 r_issue_valid;
    logic [WID_W-1:0]     r_issue_wid;
    logic [INSTR_W-1:0]   r_issue_instr;
    logic [NUM_WARPS-1:0] r_br_pending;
    logic [NUM_WARPS-1:0] r_bar_wait;

    assign w_advance = !r_issue_valid || bus.issue_ready;

    // Gating with rst keeps ibuf_pop quiet while reset is held.
    assign w_eligible = {NUM_WARPS{w_advance & rst}} & bus.warp_active & bus.ibuf_valid
                      & bus.sb_clear & ~r_br_pending & ~r_bar_wait;

    rr_prioritizer #(.WIDTH(NUM_WARPS)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .i_req   (w_eligible),
        .o_grant (w_grant)
    );

    assign w_grant_idx   = WID_W'(onehot_to_idx(MAX_WARPS'(w_grant)));
    assign w_grant_instr = bus.ibuf_instr[w_grant_idx*INSTR_W +: INSTR_W];

    always_comb begin
        w_res_clr = '0;
        if (bus.br_resolve_valid) w_res_clr[bus.br_resolve_wid] = 1'b1;
    end

    // Set is ORed in after the clear so a same-cycle set wins.
    assign w_br_next = (r_br_pending & ~w_res_clr) | (w_grant & bus.ibuf_is_branch);

    // Inactive warps count as arrived at the barrier.
    assign w_release  = (|r_bar_wait) && (&(r_bar_wait | ~bus.warp_active));
    assign w_bar_next = ((w_release ? '0 : r_bar_wait) | (w_grant & bus.ibuf_is_barrier))
                      & bus.warp_active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issue_valid <= 1'b0;
            r_issue_wid   <= '0;
            r_issue_instr <= '0;
            r_br_pending  <= '0;
            r_bar_wait    <= '0;
        end else begin
            r_br_pending <= w_br_next;
            r_bar_wait   <= w_bar_next;
            if (w_advance) begin
                r_issue_valid <= |w_grant;
                if (|w_grant) begin
                    r_issue_wid   <= w_grant_idx;
                    r_issue_instr <= w_grant_instr;
                end
            end
        end
    end

    assign bus.ibuf_pop    = w_grant;
    assign bus.issue_valid = r_issue_valid;
    assign bus.issue_wid   = r_issue_wid;
    assign bus.issue_instr = r_issue_instr;
    assign bus.br_pending  = r_br_pending;
    assign bus.bar_wait    = r_bar_wait;

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Directed bench for warp_issue_scheduler: vector table of per-cycle
// stimulus/expectations plus hand-written sweep and mid-stall reset sequences.
module tb_warp_issue_scheduler;
    import warp_issue_scheduler_pkg::*;

    typedef struct {
        bit         do_rst;
        logic [7:0] act;
        logic [7:0] val;
        logic [7:0] br;
        logic [7:0] bar;
        logic [7:0] clr;
        logic       rdy;
        logic       rv;
        logic [2:0] rwid;
        logic [7:0] e_pop;
        logic       e_iv;
        logic [2:0] e_wid;
        logic [7:0] e_br;
        logic [7:0] e_bar;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    warp_issue_scheduler_if #(.NUM_WARPS(8), .INSTR_W(32)) bus ();

    warp_issue_scheduler #(.NUM_WARPS(8), .INSTR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit r, input logic [7:0] act, input logic [7:0] val,
                                input logic [7:0] br, input logic [7:0] bar,
                                input logic [7:0] clr, input logic rdy, input logic rv,
                                input logic [2:0] rwid, input logic [7:0] e_pop,
                                input logic e_iv, input logic [2:0] e_wid,
                                input logic [7:0] e_br, input logic [7:0] e_bar);
        vec_t v;
        v.do_rst = r;   v.act = act;     v.val = val;   v.br = br;     v.bar = bar;
        v.clr = clr;    v.rdy = rdy;     v.rv = rv;     v.rwid = rwid;
        v.e_pop = e_pop; v.e_iv = e_iv;  v.e_wid = e_wid; v.e_br = e_br; v.e_bar = e_bar;
        return v;
    endfunction

    // Leaves time at posedge+1 with reset released.
    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic drive(input logic [7:0] act, input logic [7:0] val, input logic [7:0] br,
                         input logic [7:0] bar, input logic [7:0] clr, input logic rdy,
                         input logic rv, input logic [2:0] rwid);
        bus.warp_active      = act;
        bus.ibuf_valid       = val;
        bus.ibuf_is_branch   = br;
        bus.ibuf_is_barrier  = bar;
        bus.sb_clear         = clr;
        bus.issue_ready      = rdy;
        bus.br_resolve_valid = rv;
        bus.br_resolve_wid   = rwid;
    endtask

    function automatic logic [31:0] instr_of(input logic [2:0] w);
        return 32'hC0DE_0000 | {29'd0, w};
    endfunction

    initial begin
        logic [7:0]  e_pop;
        logic [2:0]  e_wid;
        issue_slot_t zero_slot;
        zero_slot = '0;

        rst = 1'b0;
        for (int w = 0; w < 8; w++) bus.ibuf_instr[w*32 +: 32] = instr_of(3'(w));
        drive(8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 3'd0);

        // Reset state with every warp otherwise eligible.
        #12;
        chk("reset issue_valid", 64'(bus.issue_valid), 64'd0);
        chk("reset slot", 64'({bus.issue_wid, bus.issue_instr}), 64'(zero_slot));
        chk("reset br_pending", 64'(bus.br_pending), 64'd0);
        chk("reset bar_wait", 64'(bus.bar_wait), 64'd0);
        chk("reset ibuf_pop", 64'(bus.ibuf_pop), 64'd0);

        // Full round-robin sweep with all warps eligible.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            e_pop = 8'h01 << (i % 8);
            e_wid = 3'(i % 8);
            #3 chk($sformatf("sweep%0d pop", i), 64'(bus.ibuf_pop), 64'(e_pop));
            @(posedge clk); #1;
            chk($sformatf("sweep%0d valid", i), 64'(bus.issue_valid), 64'd1);
            chk($sformatf("sweep%0d wid", i), 64'(bus.issue_wid), 64'(e_wid));
            chk($sformatf("sweep%0d instr", i), 64'(bus.issue_instr), 64'(instr_of(e_wid)));
        end

        // Stall: warps 2,5; ready low for 4 cycles after the first issue; then sb_clear masks 5.
        vecs.push_back(mk(1, 8'h24, 8'h24, 8'h00, 8'h00, 8'hFF, 0, 0, 0, 8'h04, 1, 2, 8'h00, 8'h00));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 8'h24, 8'h24, 8'h00, 8'h00, 8'hFF, 0, 0, 0, 8'h00, 1, 2, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'h24, 8'h24, 8'h00, 8'h00, 8'hFF, 1, 0, 0, 8'h20, 1, 5, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'h24, 8'h24, 8'h00, 8'h00, 8'hDF, 1, 0, 0, 8'h04, 1, 2, 8'h00, 8'h00));
        // Branch on warp 3: same-cycle resolve loses to set, stray resolve ignored, then real resolve.
        vecs.push_back(mk(1, 8'hFF, 8'h0A, 8'h08, 8'h00, 8'hFF, 1, 0, 0, 8'h02, 1, 1, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'hFF, 8'h0A, 8'h08, 8'h00, 8'hFF, 1, 1, 3, 8'h08, 1, 3, 8'h08, 8'h00));
        vecs.push_back(mk(0, 8'hFF, 8'h0A, 8'h08, 8'h00, 8'hFF, 1, 1, 5, 8'h02, 1, 1, 8'h08, 8'h00));
        vecs.push_back(mk(0, 8'hFF, 8'h0A, 8'h08, 8'h00, 8'hFF, 1, 1, 3, 8'h02, 1, 1, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'hFF, 8'h0A, 8'h00, 8'h00, 8'hFF, 1, 0, 0, 8'h08, 1, 3, 8'h00, 8'h00));
        // Barrier across warps 0-3, release the cycle after all arrive.
        vecs.push_back(mk(1, 8'h0F, 8'h0F, 8'h00, 8'h0F, 8'hFF, 1, 0, 0, 8'h01, 1, 0, 8'h00, 8'h01));
        vecs.push_back(mk(0, 8'h0F, 8'h0F, 8'h00, 8'h0F, 8'hFF, 1, 0, 0, 8'h02, 1, 1, 8'h00, 8'h03));
        vecs.push_back(mk(0, 8'h0F, 8'h0F, 8'h00, 8'h0F, 8'hFF, 1, 0, 0, 8'h04, 1, 2, 8'h00, 8'h07));
        vecs.push_back(mk(0, 8'h0F, 8'h0F, 8'h00, 8'h0F, 8'hFF, 1, 0, 0, 8'h08, 1, 3, 8'h00, 8'h0F));
        vecs.push_back(mk(0, 8'h0F, 8'h0F, 8'h00, 8'h0F, 8'hFF, 1, 0, 0, 8'h00, 0, 3, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'hFF, 1, 0, 0, 8'h01, 1, 0, 8'h00, 8'h00));
        // Warps 0,1 at barrier (warp 0 also branch), warp 2 exits -> release.
        vecs.push_back(mk(1, 8'h07, 8'h07, 8'h01, 8'h03, 8'hFF, 1, 0, 0, 8'h01, 1, 0, 8'h01, 8'h01));
        vecs.push_back(mk(0, 8'h07, 8'h07, 8'h01, 8'h03, 8'hFF, 1, 0, 0, 8'h02, 1, 1, 8'h01, 8'h03));
        vecs.push_back(mk(0, 8'h07, 8'h07, 8'h01, 8'h03, 8'hFF, 1, 0, 0, 8'h04, 1, 2, 8'h01, 8'h03));
        vecs.push_back(mk(0, 8'h03, 8'h07, 8'h01, 8'h03, 8'hFF, 1, 0, 0, 8'h00, 0, 2, 8'h01, 8'h00));
        vecs.push_back(mk(0, 8'h03, 8'h07, 8'h00, 8'h00, 8'hFF, 1, 1, 0, 8'h02, 1, 1, 8'h00, 8'h00));

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) do_reset();
            drive(vecs[i].act, vecs[i].val, vecs[i].br, vecs[i].bar, vecs[i].clr,
                  vecs[i].rdy, vecs[i].rv, vecs[i].rwid);
            #3 chk($sformatf("v%0d pop", i), 64'(bus.ibuf_pop), 64'(vecs[i].e_pop));
            @(posedge clk); #1;
            chk($sformatf("v%0d valid", i), 64'(bus.issue_valid), 64'(vecs[i].e_iv));
            chk($sformatf("v%0d wid", i), 64'(bus.issue_wid), 64'(vecs[i].e_wid));
            chk($sformatf("v%0d instr", i), 64'(bus.issue_instr), 64'(instr_of(vecs[i].e_wid)));
            chk($sformatf("v%0d br_pending", i), 64'(bus.br_pending), 64'(vecs[i].e_br));
            chk($sformatf("v%0d bar_wait", i), 64'(bus.bar_wait), 64'(vecs[i].e_bar));
        end

        // Async reset while stalled with a held branch issue on warp 4.
        do_reset();
        drive(8'hFF, 8'h10, 8'h10, 8'h00, 8'hFF, 1'b0, 1'b0, 3'd0);
        #3 chk("mid pop4", 64'(bus.ibuf_pop), 64'h10);
        @(posedge clk); #1;
        chk("mid held valid", 64'(bus.issue_valid), 64'd1);
        chk("mid br_pending", 64'(bus.br_pending), 64'h10);
        drive(8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 3'd0);
        #3 chk("mid stalled pop", 64'(bus.ibuf_pop), 64'd0);
        @(posedge clk); #2 rst = 1'b0;
        #1;
        chk("async rst valid", 64'(bus.issue_valid), 64'd0);
        chk("async rst slot", 64'({bus.issue_wid, bus.issue_instr}), 64'(zero_slot));
        chk("async rst br_pending", 64'(bus.br_pending), 64'd0);
        chk("async rst bar_wait", 64'(bus.bar_wait), 64'd0);
        chk("async rst pop", 64'(bus.ibuf_pop), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        drive(8'hFF, 8'h30, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 3'd0);
        #3 chk("post rst pop", 64'(bus.ibuf_pop), 64'h10);
        @(posedge clk); #1;
        chk("post rst valid", 64'(bus.issue_valid), 64'd1);
        chk("post rst wid", 64'(bus.issue_wid), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/warp_issue_scheduler.md
Name: warp_issue_scheduler

Overview:
Selects one warp per cycle to issue from the per-warp instruction buffers into the operand-collect/issue stage. Eligibility combines IBuffer-valid, scoreboard-clear, warp-active, and two scheduler-held blocking states: branch-pending and barrier-wait. Selection among eligible warps is round-robin. The chosen instruction is latched into a registered issue slot with a valid/ready handshake to the downstream pipe.

Parameters:
NUM_WARPS, 8, number of warps and IBuffer entries arbitrated; power of two, >=2
INSTR_W, 32, instruction word width carried from IBuffer to issue slot
WID_W, $clog2(NUM_WARPS), warp-id width (derived localparam, not overridable)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
warp_active  input  NUM_WARPS  warp is launched and not exited
ibuf_valid  input  NUM_WARPS  IBuffer head entry is valid per warp
ibuf_instr  input  NUM_WARPS*INSTR_W  head instruction per warp, warp w at [w*INSTR_W +: INSTR_W]
ibuf_is_branch  input  NUM_WARPS  head instruction is a branch/jump
ibuf_is_barrier  input  NUM_WARPS  head instruction is a barrier
sb_clear  input  NUM_WARPS  scoreboard reports no hazard for head instruction
ibuf_pop  output  NUM_WARPS  one-hot, combinational; dequeue head of granted warp this cycle
br_resolve_valid  input  1  branch resolution returning from the branch unit
br_resolve_wid  input  WID_W  warp whose branch resolved
issue_valid  output  1  issue slot holds an instruction
issue_ready  input  1  downstream accepts the issue slot
issue_wid  output  WID_W  warp id of the issue slot
issue_instr  output  INSTR_W  instruction in the issue slot
br_pending  output  NUM_WARPS  per-warp branch-pending flags (debug/scoreboard visibility)
bar_wait  output  NUM_WARPS  per-warp barrier-wait flags

Behaviour:
- advance = !issue_valid || issue_ready.
- eligible[w] = warp_active & ibuf_valid & sb_clear & ~br_pending & ~bar_wait, and advance.
  - When advance=0, eligible is all-zero, so the RR pointer does not move and no pop occurs.
- Round-robin grant over eligible. The most recent grantee has the lowest priority next time. After reset, warp 0 has the highest priority.
  - The pointer updates only when eligible is non-zero.
- ibuf_pop = grant. It is combinational, the same cycle as the selection. At most one bit is set.
- Issue slot register, updated when advance:
  - Some grant: issue_valid<=1, issue_wid<=encode(grant), issue_instr<=ibuf_instr of the granted warp.
  - No grant: issue_valid<=0; issue_wid and issue_instr hold.
  - Latency: eligible in cycle N -> issue_valid in cycle N+1.
  - Back-to-back issue is possible every cycle while issue_ready=1.
- br_pending[w]:
  - Set on the grant cycle when ibuf_is_branch[w].
  - Cleared on br_resolve_valid with br_resolve_wid==w.
  - Resolve for a non-pending warp is ignored.
  - Set and clear of the same warp in one cycle: set wins.
- bar_wait[w]:
  - Set on the grant cycle when ibuf_is_barrier[w].
  - Release condition: bar_wait!=0 and (bar_wait | ~warp_active) is all-ones. On release, all bar_wait bits clear the next cycle; a new set in the release cycle is kept.
  - A warp becoming inactive while others wait counts as arrived.
  - bar_wait bits of inactive warps are cleared.
- A branch that is also flagged barrier sets both flags.
- Reset (asynchronous, any time, including with issue_valid=1 and a stalled downstream) clears:
  - issue_valid, issue_wid, issue_instr, br_pending, bar_wait;
  - the RR pointer, to the state where warp 0 has the highest priority.
  - The held instruction is dropped; ibuf_pop is 0 during reset.
- The scheduler holds no state from ibuf_valid/sb_clear; those may change freely every cycle.

Decomposition:
- Shared GPU package holds:
  - NUM_WARPS default and WID_W derivation;
  - issue-slot payload struct (wid, instr);
  - a onehot-to-index function.
- One sub-module: the team's existing rr_prioritizer (WIDTH=NUM_WARPS), fed with eligible (already gated by advance).
- Branch/barrier flag logic, encoder and issue register stay in this module.

Test Plan:
- Reset, all 8 warps active/valid/clear, issue_ready=1 -> issue_wid sequence 0,1,2,...,7,0 on consecutive cycles from cycle 2 after reset; one ibuf_pop bit per cycle.
- Warps 2 and 5 eligible, issue_ready=0 for 4 cycles after first issue -> issue_wid=2 held with issue_valid=1, ibuf_pop=0 while stalled; on ready=1 the next issue is warp 5.
- Warp 3 issues a branch -> br_pending[3]=1; warp 3 is skipped despite valid; br_resolve_valid with wid=3 -> warp 3 is granted on its next RR turn.
- Warps 0-3 active, each issues a barrier in turn -> bar_wait goes 0001,0011,0111,1111, then 0000 next cycle; no warp is granted while waiting.
- Warps 0,1 at barrier, warp 2 still running; warp 2 deasserts warp_active -> barrier releases the next cycle.
- Assert rst mid-stall with issue_valid=1, br_pending=8'h10 -> all outputs 0 immediately; first post-reset grant goes to the lowest eligible warp index.
